// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
//
// Four-slot TDM demultiplexer. The block hunts for a frame marker (sync
// together with the slot-0 bit) and then captures slots 0-2 into shadow
// registers. On the slot-3 sample the whole frame is transferred to the
// out0-out3 lanes and valid pulses for one cycle. Framing errors (a missing
// sync at slot 0, or an early sync at slot 1-3) set a sticky err flag.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   din          serial TDM data bit
//   sync         frame marker, high with the slot-0 bit
//   en           sample strobe; din/sync are only looked at when en=1
//   clr_err      synchronous clear of err (a same-cycle error wins)
//   out0..out3   registered lanes for slots 0..3, held between frames
//   valid        one-cycle pulse: out0..out3 were just updated
//   slot         index of the next slot to be sampled
//   locked       high while the FSM is in LOCKED
//   err          sticky framing-error flag
//   frame_cnt    8-bit wrapping count of valid pulses (optional)
//
// Optional feature: define TDM_DEMUX4_FRAME_CNT_EN to add the frame_cnt port.
// -----------------------------------------------------------------------------
module tdm_demux4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       sync,
  input  logic       en,
  input  logic       clr_err,
  output logic       out0,
  output logic       out1,
  output logic       out2,
  output logic       out3,
  output logic       valid,
  output logic [1:0] slot,
  output logic       locked,
  output logic       err
`ifdef TDM_DEMUX4_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t     state_reg;
  logic [1:0] slot_reg;
  logic [2:0] shadow_reg;
  logic [3:0] out_reg;
  logic       valid_reg;
  logic       err_reg;
  logic       err_set;
`ifdef TDM_DEMUX4_FRAME_CNT_EN
  logic [7:0] frame_cnt_reg;
`endif

  // A framing error is only possible on a sampled bit while locked:
  // sync must be present at slot 0 and absent at slots 1-3.
  always_comb begin
    err_set = 1'b0;
    if (en && (state_reg == LOCKED)) begin
      if (sync) err_set = (slot_reg != 2'd0);
      else      err_set = (slot_reg == 2'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= HUNT;
      slot_reg      <= 2'd0;
      shadow_reg    <= 3'b000;
      out_reg       <= 4'b0000;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
`ifdef TDM_DEMUX4_FRAME_CNT_EN
      frame_cnt_reg <= 8'd0;
`endif
    end else begin
      valid_reg <= 1'b0;

      // Set has priority over clear so a coincident error is never lost.
      if (err_set)      err_reg <= 1'b1;
      else if (clr_err) err_reg <= 1'b0;

      if (en) begin
        case (state_reg)
          HUNT: begin
            if (sync) begin
              shadow_reg[0] <= din;
              slot_reg      <= 2'd1;
              state_reg     <= LOCKED;
            end
          end
          LOCKED: begin
            if (sync) begin
              // Normal frame start at slot 0, or an early sync that restarts
              // the frame; stale shadow bits are overwritten before use.
              shadow_reg[0] <= din;
              slot_reg      <= 2'd1;
            end else if (slot_reg == 2'd0) begin
              // Missing sync: drop the bit and look for a marker again.
              state_reg <= HUNT;
              slot_reg  <= 2'd0;
            end else if (slot_reg == 2'd3) begin
              out_reg   <= {din, shadow_reg};
              valid_reg <= 1'b1;
              slot_reg  <= 2'd0;
`ifdef TDM_DEMUX4_FRAME_CNT_EN
              frame_cnt_reg <= frame_cnt_reg + 8'd1;
`endif
            end else begin
              case (slot_reg)
                2'd1:    shadow_reg[1] <= din;
                default: shadow_reg[2] <= din;
              endcase
              slot_reg <= slot_reg + 2'd1;
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

  assign out0   = out_reg[0];
  assign out1   = out_reg[1];
  assign out2   = out_reg[2];
  assign out3   = out_reg[3];
  assign valid  = valid_reg;
  assign slot   = slot_reg;
  assign locked = (state_reg == LOCKED);
  assign err    = err_reg;
`ifdef TDM_DEMUX4_FRAME_CNT_EN
  assign frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the clock and reset ports are listed first below.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 din  input  1  time-multiplexed serial data bit.
REQ-005 sync  input  1  frame marker; high together with the slot-0 bit.
REQ-006 en  input  1  sample strobe; din/sync are evaluated only in cycles with en=1.
REQ-007 clr_err  input  1  synchronous clear of err.
REQ-008 out0, out1, out2, out3  output  1 each  registered demultiplexed lanes for slots 0-3.
REQ-009 valid  output  1  one-cycle pulse marking that out0-out3 have been updated with a complete frame.
REQ-010 slot  output  2  index of the next slot to be sampled.
REQ-011 locked  output  1  high in state LOCKED.
REQ-012 err  output  1  sticky framing-error flag.

Function
REQ-013 The FSM SHALL have two states: HUNT and LOCKED.
REQ-014 Cycles with en=0 SHALL leave all state unchanged, except for the clr_err action, and SHALL drive valid=0.
REQ-015 HUNT, en=1, sync=0: the bit SHALL be discarded and the FSM SHALL stay in HUNT.
REQ-016 HUNT, en=1, sync=1: din SHALL be stored in shadow0, slot SHALL be set to 1, and the FSM SHALL go to LOCKED.
REQ-017 LOCKED, en=1, slot 1-2, sync=0: din SHALL be stored in shadow[slot] and slot SHALL increment.
REQ-018 LOCKED, en=1, slot=3, sync=0: on the same edge out0..out2<=shadow0..2, out3<=din, valid<=1 for one cycle, and slot<=0.
REQ-019 Output latency SHALL be one clock from the slot-3 sample edge; out0-out3 SHALL hold between frames.
REQ-020 LOCKED, en=1, slot=0, sync=1: din SHALL be stored in shadow0 and slot<=1.
REQ-021 LOCKED, en=1, slot=0, sync=0 (missing sync): err<=1, the FSM SHALL go to HUNT, slot<=0, and the bit SHALL be discarded.
REQ-022 LOCKED, en=1, slot 1-3, sync=1 (early sync): err<=1, the partial frame SHALL be discarded with no valid pulse, din SHALL be stored in shadow0, slot<=1, and the FSM SHALL stay LOCKED.
REQ-023 err SHALL set on any framing error, and SHALL clear only through clr_err or reset.
REQ-024 If an error and clr_err occur in the same cycle, err SHALL be 1 after the edge (set wins).
REQ-025 Shadow registers SHALL NOT be visible on the outputs before frame completion.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force: FSM=HUNT, slot=0, shadow0-2=0, out0-out3=0, valid=0, locked=0, err=0 (and frame_cnt=0 when present).
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL require a fresh sync.
REQ-028 Deassertion SHALL take effect at the first rising clk edge with rst_n=1.

Configuration
REQ-029 When macro TDM_DEMUX4_FRAME_CNT_EN is defined, the block SHALL add an 8-bit output frame_cnt that increments on every valid pulse and wraps from 255 to 0.
REQ-030 When TDM_DEMUX4_FRAME_CNT_EN is undefined, port frame_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then en=1 every cycle, din=1,0,1,1 with sync on the first bit -> one cycle after the 4th sample, out0..3=1,0,1,1, valid=1 for exactly one cycle, and locked=1.
REQ-032 Same frame with en toggled 1,0,1,0,... -> identical outputs; valid is asserted one cycle after the 4th en=1 sample; slot holds during en=0 cycles.
REQ-033 LOCKED after one good frame, then sync=1 at slot 2 -> err=1, no valid pulse, slot=1; the next three samples complete the new frame with valid=1.
REQ-034 LOCKED with slot=0 and en=1, sync=0 -> err=1, locked=0 next cycle; subsequent data without sync produces no valid; clr_err=1 -> err=0.
REQ-035 rst_n pulsed low between slots 1 and 2 -> all outputs 0 immediately (no clock needed); the block returns to HUNT.
REQ-036 With TDM_DEMUX4_FRAME_CNT_EN defined: 257 consecutive good frames -> frame_cnt=1; error-aborted frames do not increment frame_cnt.
